dht22_sequenciador_bcd: RTL

Downstream consumer and scheduler for the DHT22 reader wrapper. It drives the reader's iniciar_leitura level on a fixed sampling interval and captures each returned umidade/temperatura word. It validates the checksum and range, then converts the sign-magnitude tenths values to packed BCD with a sequential double-dabble. It publishes display-ready registers for the 7-segment/UART stages, plus ok/error statistics.

---
 rtl/dht22_sequenciador_bcd.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dht22_sequenciador_bcd.sv
// Scheduler and BCD publisher for the DHT22 reader: triggers a reading every interval,
// validates the result, converts humidity/temperature tenths to BCD and publishes them.
module dht22_sequenciador_bcd #(
  parameter int INTERVALO_CICLOS = 50_000_000,
  parameter int TIMEOUT_CICLOS   = 2_500_000,
  parameter int UMID_MAX         = 1000,
  parameter int TEMP_MAX         = 1250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        disparo_manual,
  output logic        iniciar_leitura,
  input  logic        dados_prontos,
  input  logic        checksum_ok,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
  output logic [15:0] umid_bcd,
  output logic [15:0] temp_bcd,
  output logic        temp_negativa,
  output logic        valido,
  output logic        novo_dado,
  output logic [7:0]  leituras_ok,
  output logic [7:0]  erros,
  output logic [2:0]  estado_depuracao
);

  typedef enum logic [2:0] {
    S_ESPERA  = 3'd0,
    S_DISPARO = 3'd1,
    S_CONV_U  = 3'd2,
    S_CONV_T  = 3'd3,
    S_PUBLICA = 3'd4
  } estado_t;

  localparam logic [31:0] ULTIMO_INTERVALO = 32'(INTERVALO_CICLOS - 1);
  localparam logic [31:0] ULTIMO_TIMEOUT   = 32'(TIMEOUT_CICLOS - 1);
  localparam logic [15:0] UMID_LIMITE      = 16'(UMID_MAX);
  localparam logic [14:0] TEMP_LIMITE      = 15'(TEMP_MAX);

  estado_t     estado, proximo;
  logic [31:0] contador;
  logic [3:0]  iteracao;
  logic [15:0] temp_reg;
  logic [13:0] binario;
  logic [15:0] bcd;
  logic [15:0] umid_conv;
  logic [15:0] bcd_passo;
  logic        leitura_valida, fim_intervalo, fim_timeout, fim_conv;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [15:0] dabble(input logic [15:0] acc, input logic bit_in);
    logic [15:0] ajustado;
    ajustado = acc;
    for (int d = 0; d < 4; d++) begin
      if (ajustado[d*4 +: 4] >= 4'd5)
        ajustado[d*4 +: 4] = ajustado[d*4 +: 4] + 4'd3;
    end
    return {ajustado[14:0], bit_in};
  endfunction

  assign leitura_valida   = checksum_ok && (umidade <= UMID_LIMITE) && (temperatura[14:0] <= TEMP_LIMITE);
  assign fim_intervalo    = (contador == ULTIMO_INTERVALO);
  assign fim_timeout      = (contador == ULTIMO_TIMEOUT);
  assign fim_conv         = (iteracao == 4'd13);
  assign bcd_passo        = dabble(bcd, binario[13]);
  assign estado_depuracao = estado;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) estado <= S_ESPERA;
    else          estado <= proximo;
  end

  always_comb begin
    proximo         = estado;
    iniciar_leitura = 1'b0;
    case (estado)
      S_ESPERA:  if (fim_intervalo || disparo_manual) proximo = S_DISPARO;
      S_DISPARO: begin
        iniciar_leitura = 1'b1;
        if (dados_prontos)    proximo = leitura_valida ? S_CONV_U : S_ESPERA;
        else if (fim_timeout) proximo = S_ESPERA;
      end
      S_CONV_U:  if (fim_conv) proximo = S_CONV_T;
      S_CONV_T:  if (fim_conv) proximo = S_PUBLICA;
      S_PUBLICA: proximo = S_ESPERA;
      default:   proximo = S_ESPERA;
    endcase
  end

  // The same counter times the wait interval and the read timeout; it restarts on every exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      contador      <= '0;
      iteracao      <= '0;
      temp_reg      <= '0;
      binario       <= '0;
      bcd           <= '0;
      umid_conv     <= '0;
      umid_bcd      <= '0;
      temp_bcd      <= '0;
      temp_negativa <= 1'b0;
      valido        <= 1'b0;
      novo_dado     <= 1'b0;
      leituras_ok   <= '0;
      erros         <= '0;
    end else begin
      novo_dado <= 1'b0;
      case (estado)
        S_ESPERA: begin
          if (fim_intervalo || disparo_manual) contador <= '0;
          else                                 contador <= contador + 32'd1;
        end
        S_DISPARO: begin
          if (dados_prontos) begin
            contador <= '0;
            temp_reg <= temperatura;
            binario  <= umidade[13:0];
            bcd      <= '0;
            iteracao <= '0;
            if (!leitura_valida && erros != 8'hFF) erros <= erros + 8'd1;
          end else if (fim_timeout) begin
            contador <= '0;
            if (erros != 8'hFF) erros <= erros + 8'd1;
          end else begin
            contador <= contador + 32'd1;
          end
        end
        S_CONV_U: begin
          if (fim_conv) begin
            umid_conv <= bcd_passo;
            binario   <= temp_reg[13:0];
            bcd       <= '0;
            iteracao  <= '0;
          end else begin
            bcd      <= bcd_passo;
            binario  <= {binario[12:0], 1'b0};
            iteracao <= iteracao + 4'd1;
          end
        end
        S_CONV_T: begin
          bcd      <= bcd_passo;
          binario  <= {binario[12:0], 1'b0};
          iteracao <= fim_conv ? 4'd0 : iteracao + 4'd1;
        end
        S_PUBLICA: begin
          umid_bcd      <= umid_conv;
          temp_bcd      <= bcd;
          temp_negativa <= temp_reg[15] && (temp_reg[14:0] != 15'd0);
          valido        <= 1'b1;
          novo_dado     <= 1'b1;
          if (leituras_ok != 8'hFF) leituras_ok <= leituras_ok + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
